// File: rtl/laser_host.sv
// laser_host: streams a stored point set into an external laser engine,
// waits for its two-centre result, scores how many stored points fall
// within radius 4 of either centre, and reports the result.
//
// Ports
//   CLK, RST                       clock (rising edge), async active-high reset
//   wr_en, wr_addr, wr_x, wr_y     point-buffer write port, honoured only in IDLE
//   start                          run request, sampled in IDLE
//   busy                           high whenever a run is in progress
//   L_RST, L_X, L_Y                engine reset and streamed point
//   L_C1X..L_C2Y, L_DONE           engine result centres and completion flag
//   res_c1x..res_c2y               captured centres
//   res_score, res_valid, timeout  covered count, one-cycle strobe, timeout flag
module laser_host #(
  parameter int NPTS = 40,
  parameter int TMO  = 65535
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       wr_en,
  input  logic [5:0] wr_addr,
  input  logic [3:0] wr_x,
  input  logic [3:0] wr_y,
  input  logic       start,
  output logic       busy,
  output logic       L_RST,
  output logic [3:0] L_X,
  output logic [3:0] L_Y,
  input  logic [3:0] L_C1X,
  input  logic [3:0] L_C1Y,
  input  logic [3:0] L_C2X,
  input  logic [3:0] L_C2Y,
  input  logic       L_DONE,
  output logic [3:0] res_c1x,
  output logic [3:0] res_c1y,
  output logic [3:0] res_c2x,
  output logic [3:0] res_c2y,
  output logic [5:0] res_score,
  output logic       res_valid,
  output logic       timeout
);

  typedef enum logic [2:0] {
    S_IDLE, S_RSTP, S_GAP, S_SEND, S_WAIT, S_SCORE, S_REPORT
  } state_t;

  localparam logic [5:0]  LAST_IDX = 6'(NPTS - 1);
  localparam logic [15:0] TMO_LAST = 16'(TMO - 1);

  state_t      state_q;
  logic [7:0]  pbuf_q [NPTS];   // {x, y}; intentionally not reset
  logic [5:0]  idx_q;
  logic [15:0] tmo_q;
  logic [5:0]  score_q;
  logic        l_rst_q;
  logic [3:0]  lx_q, ly_q;
  logic [3:0]  c1x_q, c1y_q, c2x_q, c2y_q;
  logic [5:0]  res_score_q;
  logic        res_valid_q;
  logic        timeout_q;
  logic [7:0]  cur_pt;
  logic        hit;

  // Squared distance via |d|^2 keeps every intermediate unsigned and wide
  // enough (8-bit squares, 9-bit sum) so nothing wraps.
  function automatic logic in_circle(input logic [3:0] px, input logic [3:0] py,
                                     input logic [3:0] cx, input logic [3:0] cy);
    logic [3:0] ax, ay;
    logic [7:0] sx, sy;
    logic [8:0] sum;
    ax  = (px >= cx) ? (px - cx) : (cx - px);
    ay  = (py >= cy) ? (py - cy) : (cy - py);
    sx  = {4'b0, ax} * {4'b0, ax};
    sy  = {4'b0, ay} * {4'b0, ay};
    sum = {1'b0, sx} + {1'b0, sy};
    return sum <= 9'd16;
  endfunction

  assign cur_pt = pbuf_q[idx_q];
  assign hit    = in_circle(cur_pt[7:4], cur_pt[3:0], c1x_q, c1y_q) |
                  in_circle(cur_pt[7:4], cur_pt[3:0], c2x_q, c2y_q);

  always_ff @(posedge CLK) begin
    if (wr_en && state_q == S_IDLE && int'(wr_addr) < NPTS)
      pbuf_q[wr_addr] <= {wr_x, wr_y};
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      tmo_q       <= '0;
      score_q     <= '0;
      l_rst_q     <= 1'b0;
      lx_q        <= '0;
      ly_q        <= '0;
      c1x_q       <= '0;
      c1y_q       <= '0;
      c2x_q       <= '0;
      c2y_q       <= '0;
      res_score_q <= '0;
      res_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_RSTP;
            l_rst_q <= 1'b1;
          end
        end
        S_RSTP: begin
          state_q <= S_GAP;
          l_rst_q <= 1'b0;
        end
        // Point 0 is loaded on the GAP exit so SEND shows it in its first cycle.
        S_GAP: begin
          state_q      <= S_SEND;
          idx_q        <= '0;
          {lx_q, ly_q} <= pbuf_q[0];
        end
        S_SEND: begin
          if (idx_q == LAST_IDX) begin
            state_q      <= S_WAIT;
            {lx_q, ly_q} <= '0;
            tmo_q        <= '0;
          end else begin
            idx_q        <= idx_q + 6'd1;
            {lx_q, ly_q} <= pbuf_q[idx_q + 6'd1];
          end
        end
        S_WAIT: begin
          if (L_DONE) begin
            state_q <= S_SCORE;
            c1x_q   <= L_C1X;
            c1y_q   <= L_C1Y;
            c2x_q   <= L_C2X;
            c2y_q   <= L_C2Y;
            score_q <= '0;
            idx_q   <= '0;
          end else if (tmo_q == TMO_LAST) begin
            state_q     <= S_REPORT;
            res_valid_q <= 1'b1;
            timeout_q   <= 1'b1;
            res_score_q <= '0;
          end else begin
            tmo_q <= tmo_q + 16'd1;
          end
        end
        S_SCORE: begin
          score_q <= score_q + {5'b0, hit};
          if (idx_q == LAST_IDX) begin
            state_q     <= S_REPORT;
            res_valid_q <= 1'b1;
            timeout_q   <= 1'b0;
            res_score_q <= score_q + {5'b0, hit};
          end else begin
            idx_q <= idx_q + 6'd1;
          end
        end
        S_REPORT: begin
          state_q     <= S_IDLE;
          res_valid_q <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign L_RST     = l_rst_q | RST;
  assign L_X       = lx_q;
  assign L_Y       = ly_q;
  assign res_c1x   = c1x_q;
  assign res_c1y   = c1y_q;
  assign res_c2x   = c2x_q;
  assign res_c2y   = c2y_q;
  assign res_score = res_score_q;
  assign res_valid = res_valid_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_laser_host.sv
// Directed self-checking bench for laser_host: reset, streaming, scoring,
// boundary distances, timeout, mid-run reset and disturbance immunity.
module tb_laser_host;
  localparam int NPTS = 40;
  localparam int TMO  = 20;

  logic       CLK = 1'b0;
  logic       RST;
  logic       wr_en;
  logic [5:0] wr_addr;
  logic [3:0] wr_x, wr_y;
  logic       start;
  logic       busy, L_RST;
  logic [3:0] L_X, L_Y;
  logic [3:0] L_C1X, L_C1Y, L_C2X, L_C2Y;
  logic       L_DONE;
  logic [3:0] res_c1x, res_c1y, res_c2x, res_c2y;
  logic [5:0] res_score;
  logic       res_valid, timeout;

  always #5 CLK = ~CLK;

  laser_host #(.NPTS(NPTS), .TMO(TMO)) dut (
    .CLK(CLK), .RST(RST),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_x(wr_x), .wr_y(wr_y),
    .start(start), .busy(busy),
    .L_RST(L_RST), .L_X(L_X), .L_Y(L_Y),
    .L_C1X(L_C1X), .L_C1Y(L_C1Y), .L_C2X(L_C2X), .L_C2Y(L_C2Y),
    .L_DONE(L_DONE),
    .res_c1x(res_c1x), .res_c1y(res_c1y), .res_c2x(res_c2x), .res_c2y(res_c2y),
    .res_score(res_score), .res_valid(res_valid), .timeout(timeout)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  mem [NPTS];       // bench copy of what the buffer should hold
  logic [7:0]  r_stream [NPTS];
  logic        r_lrst, r_busy_wait, r_valid, r_busy_after, r_valid_after;
  logic [8:0]  r_gap;            // {L_RST, L_X, L_Y} during GAP
  logic [7:0]  r_after;
  int          r_wc;
  logic [5:0]  r_score;
  logic        r_tmo;
  logic [15:0] r_c;
  logic [6:0]  r_hold;

  task automatic write_pt(input int a, input logic [3:0] x, input logic [3:0] y);
    wr_en = 1'b1; wr_addr = a[5:0]; wr_x = x; wr_y = y;
    @(negedge CLK);
    wr_en = 1'b0;
    if (a < NPTS) mem[a] = {x, y};
  endtask

  // Called at a negedge with the DUT idle. done_after < 0 means the engine
  // model never completes.
  task automatic run(input logic [3:0] c1x, input logic [3:0] c1y,
                     input logic [3:0] c2x, input logic [3:0] c2y,
                     input int done_after, input bit disturb);
    L_C1X = c1x; L_C1Y = c1y; L_C2X = c2x; L_C2Y = c2y;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    r_lrst = L_RST;
    if (disturb) L_DONE = 1'b1;
    @(negedge CLK);
    r_gap = {L_RST, L_X, L_Y};
    for (int k = 0; k < NPTS; k++) begin
      @(negedge CLK);
      r_stream[k] = {L_X, L_Y};
      L_DONE = 1'b0;
      if (disturb && k == 5) begin
        start = 1'b1; wr_en = 1'b1; wr_addr = 6'd3; wr_x = 4'hA; wr_y = 4'hA;
      end else begin
        start = 1'b0; wr_en = 1'b0;
      end
    end
    @(negedge CLK);
    r_after     = {L_X, L_Y};
    r_busy_wait = busy;
    r_valid     = 1'b0;
    r_wc        = -1;
    if (disturb) begin wr_addr = 6'd3; wr_x = 4'hA; wr_y = 4'hA; end
    for (int i = 0; i < 200; i++) begin
      if (res_valid) begin
        r_valid = 1'b1;
        r_wc    = i;
        break;
      end
      L_DONE = (i == done_after);
      start  = disturb && (i == 1);
      wr_en  = disturb && (i == 1);
      @(negedge CLK);
    end
    L_DONE = 1'b0; start = 1'b0; wr_en = 1'b0;
    r_score = res_score;
    r_tmo   = timeout;
    r_c     = {res_c1x, res_c1y, res_c2x, res_c2y};
    @(negedge CLK);
    r_busy_after  = busy;
    r_valid_after = res_valid;
    r_hold        = {res_score, timeout};
  endtask

  task automatic test_reset;
    RST = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_x = '0; wr_y = '0; start = 1'b0;
    L_C1X = '0; L_C1Y = '0; L_C2X = '0; L_C2Y = '0; L_DONE = 1'b0;
    @(negedge CLK); @(negedge CLK);
    n_checks++;
    if (L_RST !== 1'b1) begin n_fail++; $display("FAIL reset_lrst: got %b want 1", L_RST); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++;
    if ({L_X, L_Y} !== 8'h00) begin n_fail++; $display("FAIL reset_lxy: got %h want 00", {L_X, L_Y}); end
    n_checks++;
    if ({res_score, res_valid, timeout} !== 8'h00) begin
      n_fail++; $display("FAIL reset_res: got %h want 00", {res_score, res_valid, timeout});
    end
    n_checks++;
    if ({res_c1x, res_c1y, res_c2x, res_c2y} !== 16'h0000) begin
      n_fail++; $display("FAIL reset_centres: got %h want 0000", {res_c1x, res_c1y, res_c2x, res_c2y});
    end
    RST = 1'b0;
    @(negedge CLK);
    n_checks++;
    if (L_RST !== 1'b0) begin n_fail++; $display("FAIL reset_release_lrst: got %b want 0", L_RST); end
  endtask

  task automatic test_stream_all5;
    int bad;
    for (int a = 0; a < NPTS; a++) write_pt(a, 4'd5, 4'd5);
    run(4'd5, 4'd5, 4'd10, 4'd10, 2, 1'b0);
    n_checks++;
    if (r_lrst !== 1'b1) begin n_fail++; $display("FAIL s5_lrst_pulse: got %b want 1", r_lrst); end
    n_checks++;
    if (r_gap !== 9'h000) begin n_fail++; $display("FAIL s5_gap: got %h want 000", r_gap); end
    bad = 0;
    for (int k = 0; k < NPTS; k++) if (r_stream[k] !== 8'h55) bad++;
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL s5_stream: got %0d bad points want 0", bad); end
    n_checks++;
    if (r_after !== 8'h00 || r_busy_wait !== 1'b1) begin
      n_fail++; $display("FAIL s5_wait_out: got lxy=%h busy=%b want 00/1", r_after, r_busy_wait);
    end
    n_checks++;
    if (r_wc != 43) begin n_fail++; $display("FAIL s5_latency: got %0d want 43", r_wc); end
    n_checks++;
    if (r_score !== 6'd40 || r_tmo !== 1'b0) begin
      n_fail++; $display("FAIL s5_score: got %0d/%b want 40/0", r_score, r_tmo);
    end
    n_checks++;
    if (r_c !== 16'h55AA) begin n_fail++; $display("FAIL s5_centres: got %h want 55aa", r_c); end
    n_checks++;
    if (r_busy_after !== 1'b0 || r_valid_after !== 1'b0) begin
      n_fail++; $display("FAIL s5_end: got busy=%b valid=%b want 0/0", r_busy_after, r_valid_after);
    end
    n_checks++;
    if (r_hold !== {6'd40, 1'b0}) begin n_fail++; $display("FAIL s5_hold: got %h want %h", r_hold, {6'd40, 1'b0}); end
  endtask

  task automatic test_back_to_back;
    int bad;
    for (int a = 0; a < NPTS; a++)
      if (a < 20) write_pt(a, 4'd0, 4'd0); else write_pt(a, 4'd15, 4'd15);
    run(4'd0, 4'd0, 4'd15, 4'd15, 0, 1'b0);
    bad = 0;
    for (int k = 0; k < NPTS; k++) if (r_stream[k] !== mem[k]) bad++;
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL clus_stream: got %0d bad points want 0", bad); end
    n_checks++;
    if (r_wc != 41 || r_score !== 6'd40) begin
      n_fail++; $display("FAIL clus_score40: got wc=%0d score=%0d want 41/40", r_wc, r_score);
    end
    // start issued in the first idle cycle after the report
    run(4'd0, 4'd0, 4'd0, 4'd0, 0, 1'b0);
    n_checks++;
    if (r_lrst !== 1'b1) begin n_fail++; $display("FAIL b2b_restart: got %b want 1", r_lrst); end
    n_checks++;
    if (r_score !== 6'd20 || r_tmo !== 1'b0) begin
      n_fail++; $display("FAIL clus_score20: got %0d/%b want 20/0", r_score, r_tmo);
    end
  endtask

  task automatic load_boundary;
    write_pt(0, 4'd4,  4'd0);   // d^2 = 16 to (0,0): covered
    write_pt(1, 4'd3,  4'd3);   // d^2 = 18: not covered
    write_pt(2, 4'd15, 4'd11);  // d^2 = 16 to (15,15): covered
    write_pt(3, 4'd11, 4'd15);  // negative dx, d^2 = 16: covered
    write_pt(4, 4'd15, 4'd6);   // 261 to (0,0): wraps to 5 if sum were 8-bit
    for (int a = 5; a < NPTS; a++) write_pt(a, 4'd8, 4'd8);
  endtask

  task automatic test_boundary;
    load_boundary();
    run(4'd0, 4'd0, 4'd15, 4'd15, 1, 1'b0);
    n_checks++;
    if (r_score !== 6'd3) begin n_fail++; $display("FAIL bnd_score: got %0d want 3", r_score); end
    n_checks++;
    if (r_wc != 42) begin n_fail++; $display("FAIL bnd_latency: got %0d want 42", r_wc); end
  endtask

  task automatic test_timeout;
    run(4'd1, 4'd2, 4'd3, 4'd4, -1, 1'b0);
    n_checks++;
    if (r_wc != TMO) begin n_fail++; $display("FAIL tmo_latency: got %0d want %0d", r_wc, TMO); end
    n_checks++;
    if (r_tmo !== 1'b1 || r_score !== 6'd0) begin
      n_fail++; $display("FAIL tmo_flags: got tmo=%b score=%0d want 1/0", r_tmo, r_score);
    end
    n_checks++;
    if (r_c !== 16'h00FF) begin n_fail++; $display("FAIL tmo_centres: got %h want 00ff", r_c); end
    n_checks++;
    if (r_hold !== 7'b0000001) begin n_fail++; $display("FAIL tmo_hold: got %b want 0000001", r_hold); end
    run(4'd0, 4'd0, 4'd15, 4'd15, 0, 1'b0);
    n_checks++;
    if (r_tmo !== 1'b0 || r_score !== 6'd3) begin
      n_fail++; $display("FAIL tmo_recover: got tmo=%b score=%0d want 0/3", r_tmo, r_score);
    end
  endtask

  task automatic test_reset_midrun;
    int bad;
    L_C1X = 4'd0; L_C1Y = 4'd0; L_C2X = 4'd15; L_C2Y = 4'd15;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    @(negedge CLK);
    for (int k = 0; k <= 20; k++) @(negedge CLK);
    n_checks++;
    if ({L_X, L_Y} !== mem[20]) begin n_fail++; $display("FAIL mr_idx20: got %h want %h", {L_X, L_Y}, mem[20]); end
    RST = 1'b1;
    #1;
    n_checks++;
    if (L_RST !== 1'b1 || busy !== 1'b0 || {L_X, L_Y} !== 8'h00) begin
      n_fail++; $display("FAIL mr_async: got lrst=%b busy=%b lxy=%h want 1/0/00", L_RST, busy, {L_X, L_Y});
    end
    n_checks++;
    if ({res_c1x, res_c1y, res_c2x, res_c2y, res_score, res_valid, timeout} !== 24'h0) begin
      n_fail++; $display("FAIL mr_res_zero: got %h want 000000",
                         {res_c1x, res_c1y, res_c2x, res_c2y, res_score, res_valid, timeout});
    end
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL mr_idle: got busy=%b want 0", busy); end
    run(4'd0, 4'd0, 4'd15, 4'd15, 0, 1'b0);
    bad = 0;
    for (int k = 0; k < NPTS; k++) if (r_stream[k] !== mem[k]) bad++;
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL mr_restream: got %0d bad points want 0", bad); end
    n_checks++;
    if (r_score !== 6'd3) begin n_fail++; $display("FAIL mr_score: got %0d want 3", r_score); end
  endtask

  task automatic test_disturb;
    int bad;
    run(4'd0, 4'd0, 4'd15, 4'd15, 3, 1'b1);
    n_checks++;
    if (r_wc != 44 || r_score !== 6'd3 || r_tmo !== 1'b0) begin
      n_fail++; $display("FAIL dist_result: got wc=%0d score=%0d tmo=%b want 44/3/0", r_wc, r_score, r_tmo);
    end
    write_pt(40, 4'hA, 4'hA);
    write_pt(63, 4'hA, 4'hA);
    run(4'd0, 4'd0, 4'd15, 4'd15, 3, 1'b0);
    bad = 0;
    for (int k = 0; k < NPTS; k++) if (r_stream[k] !== mem[k]) bad++;
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL dist_buffer: got %0d bad points want 0", bad); end
    n_checks++;
    if (r_wc != 44 || r_score !== 6'd3) begin
      n_fail++; $display("FAIL dist_clean: got wc=%0d score=%0d want 44/3", r_wc, r_score);
    end
  endtask

  initial begin
    test_reset();
    test_stream_all5();
    test_back_to_back();
    test_boundary();
    test_timeout();
    test_reset_midrun();
    test_disturb();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/laser_host.md
LASER_HOST -- requirements
Module: laser_host

Interface
REQ-001 SHALL have parameter NPTS, 40, number of points streamed per run.
REQ-002 SHALL have parameter TMO, 65535, maximum WAIT-state cycles before timeout.
REQ-003 SHALL have port CLK  input  1  clock, all logic on rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports wr_en/wr_addr/wr_x/wr_y  input  1/6/4/4  point-buffer write port (addr 0..NPTS-1).
REQ-006 SHALL have port start  input  1  run request, level-sampled in IDLE.
REQ-007 SHALL have port busy  output  1  high in every state except IDLE.
REQ-008 SHALL have ports L_RST/L_X/L_Y  output  1/4/4  drive the laser engine's reset and point inputs.
REQ-009 SHALL have ports L_C1X/L_C1Y/L_C2X/L_C2Y/L_DONE  input  4/4/4/4/1  engine result and completion flag.
REQ-010 SHALL have ports res_c1x/res_c1y/res_c2x/res_c2y  output  4 each  captured centres.
REQ-011 SHALL have ports res_score/res_valid/timeout  output  6/1/1  covered-point count, 1-cycle result strobe, timeout flag.

Function
REQ-012 SHALL hold NPTS x 8-bit point buffer, written when wr_en=1 and state=IDLE only; writes with wr_addr>=NPTS or outside IDLE are ignored.
REQ-013 SHALL implement FSM IDLE->RSTP->GAP->SEND->WAIT->SCORE->REPORT->IDLE.
REQ-014 IDLE: start=1 -> RSTP next cycle; start outside IDLE is ignored.
REQ-015 RSTP: one cycle, L_RST=1; GAP: one cycle, L_RST=0, L_X=L_Y=0.
REQ-016 SEND: NPTS cycles, index 0..NPTS-1, registered L_X/L_Y = buffer[index] in consecutive cycles, no gaps; after index NPTS-1 -> WAIT, L_X/L_Y return to 0.
REQ-017 start sampled at edge t -> L_RST high cycle t+1, point 0 on L_X/L_Y cycle t+3, point NPTS-1 cycle t+NPTS+2.
REQ-018 L_DONE SHALL be sampled only in WAIT; ignored in all other states.
REQ-019 WAIT: L_DONE=1 -> capture L_C1X..L_C2Y into res_c1x..res_c2y, clear score counter, -> SCORE.
REQ-020 WAIT: 16-bit cycle counter; after TMO cycles without L_DONE -> REPORT with timeout=1, res_score=0, centres unchanged.
REQ-021 SCORE: NPTS cycles, one buffered point per cycle; point covered if (x-cx)^2+(y-cy)^2 <= 16 for either captured centre.
REQ-022 Arithmetic: dx,dy signed 5-bit; squares unsigned 8-bit (max 225); sum unsigned 9-bit (max 450); compare <=16 inclusive; no truncation.
REQ-023 Covered count SHALL be 6-bit, saturating not required (max NPTS=40); point in both circles counted once.
REQ-024 REPORT: one cycle, res_valid=1, res_score=final count, timeout=1 only on timeout path; -> IDLE.
REQ-025 res_* and timeout SHALL hold their values until next REPORT or reset.
REQ-026 busy SHALL fall in the cycle res_valid is high +1 (IDLE), allowing start in the following cycle.

Reset
REQ-027 RST=1 SHALL force IDLE immediately; L_RST=1 combinationally while RST=1.
REQ-028 On reset: busy=0, L_X=L_Y=0, res_c1x..res_c2y=0, res_score=0, res_valid=0, timeout=0, counters=0.
REQ-029 Point buffer contents SHALL NOT be reset; reset mid-run abandons the run, next start restarts at index 0.

Verification
REQ-030 All 40 points (5,5); model returns C1=(5,5), C2=(10,10) -> L_X/L_Y=5 for 40 consecutive cycles from t+3, res_score=40, timeout=0.
REQ-031 Points 0..19=(0,0), 20..39=(15,15); model returns (0,0),(15,15) -> score 40; rerun with (0,0),(0,0) -> score 20.
REQ-032 Boundary: centres (0,0),(15,15); point (4,0) counted (d^2=16), point (3,3) not counted (d^2=18), point (15,11) counted.
REQ-033 Model never asserts L_DONE -> res_valid exactly TMO cycles after entering WAIT, timeout=1, res_score=0.
REQ-034 RST pulse at SEND index 20 -> busy=0, L_RST=1 during RST, outputs zero; next start streams from index 0 with prior buffer contents.
REQ-035 start and wr_en pulsed during SEND/WAIT -> no restart, buffer unchanged, result identical to undisturbed run; L_DONE high during GAP ignored.
